// File: rtl/vram_writer_pkg.sv
// Shared types and constants for the VRAM write-snoop path.
// vram_wr_t is one queued VRAM write (15-bit address, 8-bit data).
// scr_decode maps a CPU address to a VRAM address and reports whether it hits a screen bank.
package vram_writer_pkg;

    localparam int unsigned VRAM_AW = 15;
    localparam int unsigned VRAM_DW = 8;

    localparam logic [2:0] SCR_BANK_LO = 3'd5;
    localparam logic [2:0] SCR_BANK_HI = 3'd7;

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } vram_wr_t;

    // Returns {hit, vram_addr}. Fixed bank 5 at 4000-7FFF wins over a paged bank at C000-FFFF.
    function automatic logic [15:0] scr_decode(input logic [15:0] a,
                                               input logic        m128,
                                               input logic [2:0]  page);
        logic [15:0] r;
        r = '0;
        if (a[15:14] == 2'b01)
            r = {1'b1, 1'b0, a[13:0]};
        else if (m128 && a[15:14] == 2'b11 && page == SCR_BANK_LO)
            r = {1'b1, 1'b0, a[13:0]};
        else if (m128 && a[15:14] == 2'b11 && page == SCR_BANK_HI)
            r = {1'b1, 1'b1, a[13:0]};
        return r;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO of vram_wr_t entries with a tail-overwrite port.
// Ports: clk_sys/nreset clock and async active-low reset; push/pop/ovw controls;
// wdata entry in; head/tail entries out; level exact count; full/empty flags.
module vram_wr_fifo
    import vram_writer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk_sys,
    input  logic                  nreset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  ovw,
    input  vram_wr_t              wdata,
    output vram_wr_t              head,
    output vram_wr_t              tail,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    vram_wr_t               mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2-1:0]  tail_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign tail_ptr = wr_ptr - DEPTH_LOG2'(1);
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok  = push & (~full | pop);
    assign pop_ok   = pop & ~empty;

    // Storage needs no reset; entries are only read while counted by level.
    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
        else if (ovw && !empty)
            mem[tail_ptr] <= wdata;
    end

    // Pointers and exact occupancy.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (push_ok && !pop_ok)
                level <= level + LW'(1);
            else if (pop_ok && !push_ok)
                level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Snoops CPU writes to the screen banks and replays them into the VRAM write port
// in cycles the video fetch leaves free.
// Ports: clk_sys/nreset; CPU bus (addr, din, nMREQ, nWR, nRFSH); paging (m128, page_ram);
// enable; vram_busy; VRAM write port (vram_we, vram_waddr, vram_wdata);
// status (fifo_level, overflow) and overflow_clr.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk_sys,
    input  logic                  nreset,
    input  logic [15:0]           addr,
    input  logic [7:0]            din,
    input  logic                  nMREQ,
    input  logic                  nWR,
    input  logic                  nRFSH,
    input  logic                  m128,
    input  logic [2:0]            page_ram,
    input  logic                  enable,
    input  logic                  vram_busy,
    output logic                  vram_we,
    output logic [14:0]           vram_waddr,
    output logic [7:0]            vram_wdata,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int unsigned LW = DEPTH_LOG2 + 1;

    logic        wr_act_c;
    logic        wr_q;
    logic        wr_q_d;
    logic        cap_c;
    logic [15:0] dec_c;
    logic        pend_valid;
    vram_wr_t    pend;
    vram_wr_t    head;
    vram_wr_t    tail;
    logic        full;
    logic        empty;
    logic        pop_c;
    logic        coalesce_c;
    logic        drop_c;
    logic        push_c;

    // Memory write cycle, excluding refresh.
    assign wr_act_c = ~nMREQ & ~nWR & nRFSH;
    assign cap_c    = wr_q & ~wr_q_d & enable;
    assign dec_c    = scr_decode(addr, m128, page_ram);

    // Write-strobe edge detect.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            wr_q   <= 1'b0;
            wr_q_d <= 1'b0;
        end else begin
            wr_q   <= wr_act_c;
            wr_q_d <= wr_q;
        end
    end

    // Capture stage: decoded address and data wait one cycle before entering the FIFO.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            pend_valid <= 1'b0;
            pend       <= '0;
        end else begin
            pend_valid <= cap_c & dec_c[15];
            if (cap_c)
                pend <= '{addr: dec_c[14:0], data: din};
        end
    end

    assign pop_c = ~empty & ~vram_busy;

    // Repeated writes to the tail address collapse into one entry, unless that
    // tail is the only entry and is leaving this cycle.
    assign coalesce_c = pend_valid & ~empty & (tail.addr == pend.addr)
                      & ~((fifo_level == LW'(1)) & pop_c);
    assign drop_c     = pend_valid & ~coalesce_c & full & ~pop_c;
    assign push_c     = pend_valid & ~coalesce_c & ~drop_c;

    vram_wr_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_sys (clk_sys),
        .nreset  (nreset),
        .push    (push_c),
        .pop     (pop_c),
        .ovw     (coalesce_c),
        .wdata   (pend),
        .head    (head),
        .tail    (tail),
        .level   (fifo_level),
        .full    (full),
        .empty   (empty)
    );

    // Registered VRAM write port; address/data hold between pops.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            vram_we <= pop_c;
            if (pop_c) begin
                vram_waddr <= head.addr;
                vram_wdata <= head.data;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset)
            overflow <= 1'b0;
        else if (drop_c)
            overflow <= 1'b1;
        else if (overflow_clr)
            overflow <= 1'b0;
    end

endmodule
